mtl_spi_command: RTL and testbench



---
 rtl/mtl_spi_pkg.sv | 42 ++++
 rtl/mtl_spi_command_sync_edge.sv | 53 +++++
 rtl/mtl_spi_command.sv | 171 +++++++++++++++++
 tb/tb_mtl_spi_command.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtl_spi_pkg.sv
// Shared types and constants for the MTL SPI command decoder.
// Holds the opcode and FSM encodings plus the status-byte layout.
package mtl_spi_pkg;

  localparam int CUBE_W = 3;

  typedef enum logic [7:0] {
    OP_NOP        = 8'h00,
    OP_SET_CUBE   = 8'h01,
    OP_LOAD_START = 8'h02,
    OP_LOAD_END   = 8'h03
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ARG,
    ST_EXEC,
    ST_FLUSH
  } state_e;

  // Status byte returned on MISO during byte0: {err, loading, 3'b000, cube}
  localparam int STAT_ERR_BIT  = 7;
  localparam int STAT_LOAD_BIT = 6;
  localparam int STAT_CUBE_LSB = 0;

  function automatic logic opcode_known(input logic [7:0] b);
    return (b <= 8'(OP_LOAD_END));
  endfunction

  function automatic logic [7:0] status_byte(input logic err,
                                             input logic loading,
                                             input logic [CUBE_W-1:0] cube);
    logic [7:0] s;
    s = '0;
    s[STAT_ERR_BIT]              = err;
    s[STAT_LOAD_BIT]             = loading;
    s[STAT_CUBE_LSB +: CUBE_W]   = cube;
    return s;
  endfunction

endpackage

// File: rtl/mtl_spi_command_sync_edge.sv
// Multi-stage synchroniser for an asynchronous SPI pin, with registered
// one-cycle rising/falling edge pulses (pin-to-pulse latency SYNC_STAGES+1).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge iCLK or negedge iRST_n) begin
          if (!iRST_n) stage_q[gi] <= RESET_VAL;
          else         stage_q[gi] <= d_i;
        end
      end else begin : g_next
        always_ff @(posedge iCLK or negedge iRST_n) begin
          if (!iRST_n) stage_q[gi] <= RESET_VAL;
          else         stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= stage_q[SYNC_STAGES-1];
      rise_q <= stage_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~stage_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mtl_spi_command.sv
// SPI slave decoding 2-byte commands from the PIC32 into cube selection and
// loading flag for the MTL LCD controller; cube changes commit on frame start.
module mtl_spi_command
  import mtl_spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSPI_SCLK,
  input  logic              iSPI_CS_n,
  input  logic              iSPI_MOSI,
  output logic              oSPI_MISO,
  input  logic              iNewFrame,
  output logic [CUBE_W-1:0] oCube,
  output logic              oLoading,
  output logic              oCmdValid,
  output logic              oErr
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // All chains reset low: a frame already in progress (CS_n low) at reset
  // release then produces no falling edge and is ignored until CS_n toggles.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .iCLK(iCLK), .iRST_n(iRST_n), .d_i(iSPI_SCLK),
    .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .iCLK(iCLK), .iRST_n(iRST_n), .d_i(iSPI_CS_n),
    .sync_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .iCLK(iCLK), .iRST_n(iRST_n), .d_i(iSPI_MOSI),
    .sync_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  opcode_e           opcode_q;
  logic [CUBE_W-1:0] arg_cube_q;
  logic              set_cube_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [CUBE_W-1:0] pending_q;
  logic [CUBE_W-1:0] cube_q;
  logic              loading_q;
  logic              err_q;
  logic              valid_q;
  logic              miso_q;
  logic [6:0]        miso_sr_q;

  logic [7:0]        rx_byte;
  logic              lint_unused;

  assign rx_byte     = {shift_q[6:0], mosi_lvl};
  assign lint_unused = ^{shift_q[7], sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      opcode_q   <= OP_NOP;
      arg_cube_q <= '0;
      set_cube_q <= 1'b0;
      tmo_q      <= '0;
      pending_q  <= '0;
      cube_q     <= '0;
      loading_q  <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      miso_q     <= 1'b0;
      miso_sr_q  <= '0;
    end else begin
      valid_q    <= 1'b0;
      set_cube_q <= 1'b0;

      // pending_q is written one cycle after EXEC, so a frame start that
      // coincides with oCmdValid still commits the previous pending value.
      if (set_cube_q) pending_q <= arg_cube_q;
      if (iNewFrame)  cube_q    <= pending_q;

      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q              <= ST_OPCODE;
            bit_cnt_q            <= '0;
            tmo_q                <= '0;
            {miso_q, miso_sr_q}  <= status_byte(err_q, loading_q, cube_q);
          end
        end

        ST_OPCODE, ST_ARG: begin
          // A bit edge wins over a simultaneous CS_n rise so the last bit lands.
          if (sclk_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tmo_q     <= '0;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_OPCODE) begin
                miso_q <= 1'b0;
                if (opcode_known(rx_byte)) begin
                  opcode_q <= opcode_e'(rx_byte);
                  state_q  <= ST_ARG;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_FLUSH;
                end
              end else begin
                state_q <= ST_EXEC;
              end
            end
          end else if (cs_lvl) begin
            err_q   <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!sclk_fall && tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= ST_FLUSH;
          end else begin
            tmo_q <= sclk_fall ? '0 : tmo_q + TMO_W'(1);
            if (sclk_fall && state_q == ST_OPCODE) begin
              miso_q    <= miso_sr_q[6];
              miso_sr_q <= {miso_sr_q[5:0], 1'b0};
            end
          end
        end

        ST_EXEC: begin
          valid_q <= 1'b1;
          err_q   <= 1'b0;
          state_q <= ST_FLUSH;
          case (opcode_q)
            OP_SET_CUBE: begin
              set_cube_q <= 1'b1;
              arg_cube_q <= shift_q[CUBE_W-1:0];
            end
            OP_LOAD_START: loading_q <= 1'b1;
            OP_LOAD_END:   loading_q <= 1'b0;
            default: ;
          endcase
        end

        ST_FLUSH: begin
          miso_q <= 1'b0;
          if (cs_lvl) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oSPI_MISO = miso_q;
  assign oCube     = cube_q;
  assign oLoading  = loading_q;
  assign oCmdValid = valid_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_mtl_spi_command.sv
// Directed bench for mtl_spi_command: SPI commands, frame commit, errors,
// timeout, status readback and asynchronous reset mid-command.
module tb_mtl_spi_command;

  logic       iCLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       new_frame = 1'b0;
  logic       miso;
  logic [2:0] cube;
  logic       loading;
  logic       cmd_valid;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = -1;
  int rise_cyc = 0;
  int cube3_cnt = 0;
  logic load_at_valid = 1'b0;

  mtl_spi_command dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iSPI_SCLK(sclk), .iSPI_CS_n(cs_n), .iSPI_MOSI(mosi), .oSPI_MISO(miso),
    .iNewFrame(new_frame), .oCube(cube), .oLoading(loading),
    .oCmdValid(cmd_valid), .oErr(err)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    cyc <= cyc + 1;
    if (cmd_valid === 1'b1) begin
      valid_cnt     <= valid_cnt + 1;
      valid_cyc     <= cyc;
      load_at_valid <= loading;
    end
    if (cube === 3'd3) cube3_cnt <= cube3_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_cyc(6);
    m = miso;
    sclk = 1'b1;
    rise_cyc = cyc;
    wait_cyc(6);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic m;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx[7-i], m);
      rx[7-i] = m;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_cyc(10);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg, output logic [7:0] status);
    logic [7:0] dummy;
    cs_low();
    spi_byte(op, 8, status);
    spi_byte(arg, 8, dummy);
    cs_high();
  endtask

  task automatic frame();
    new_frame = 1'b1;
    wait_cyc(1);
    new_frame = 1'b0;
    wait_cyc(1);
  endtask

  task automatic do_reset();
    iRST_n = 1'b0;
    wait_cyc(3);
    iRST_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    wait_cyc(4);
    n_cmp++; if (cube !== 3'd0) begin n_bad++; $display("FAIL reset_cube: got %0d want 0", cube); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL reset_loading: got %b want 0", loading); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    iRST_n = 1'b1;
    wait_cyc(5);
    $display("test_reset done");
  endtask

  task automatic test_set_cube();
    logic [7:0] st;
    int v0;
    v0 = valid_cnt;
    send_cmd(8'h01, 8'h05, st);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL set_cube_pulses: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (valid_cyc - rise_cyc !== 5) begin n_bad++; $display("FAIL set_cube_latency: got %0d want 5 (t+2)", valid_cyc - rise_cyc); end
    n_cmp++; if (cube !== 3'd0) begin n_bad++; $display("FAIL set_cube_before_frame: got %0d want 0", cube); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL set_cube_err: got %b want 0", err); end
    wait_cyc(100);
    new_frame = 1'b1;
    n_cmp++; if (cube !== 3'd0) begin n_bad++; $display("FAIL set_cube_during_frame: got %0d want 0", cube); end
    wait_cyc(1);
    new_frame = 1'b0;
    n_cmp++; if (cube !== 3'd5) begin n_bad++; $display("FAIL set_cube_after_frame: got %0d want 5", cube); end
    wait_cyc(1);
    $display("test_set_cube: cube=%0d", cube);
  endtask

  task automatic test_overwrite();
    logic [7:0] st;
    int c3;
    do_reset();
    c3 = cube3_cnt;
    send_cmd(8'h01, 8'h03, st);
    send_cmd(8'h01, 8'h06, st);
    n_cmp++; if (cube !== 3'd0) begin n_bad++; $display("FAIL overwrite_before_frame: got %0d want 0", cube); end
    frame();
    n_cmp++; if (cube !== 3'd6) begin n_bad++; $display("FAIL overwrite_after_frame: got %0d want 6", cube); end
    n_cmp++; if (cube3_cnt !== c3) begin n_bad++; $display("FAIL overwrite_saw3: got %0d cycles want %0d", cube3_cnt, c3); end
    $display("test_overwrite: cube=%0d", cube);
  endtask

  task automatic test_loading();
    logic [7:0] st;
    int v0;
    v0 = valid_cnt;
    send_cmd(8'h02, 8'h00, st);
    n_cmp++; if (load_at_valid !== 1'b1) begin n_bad++; $display("FAIL load_start_at_valid: got %b want 1", load_at_valid); end
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL load_start: got %b want 1", loading); end
    send_cmd(8'h03, 8'h00, st);
    n_cmp++; if (load_at_valid !== 1'b0) begin n_bad++; $display("FAIL load_end_at_valid: got %b want 0", load_at_valid); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL load_end: got %b want 0", loading); end
    n_cmp++; if (valid_cnt - v0 !== 2) begin n_bad++; $display("FAIL load_pulses: got %0d want 2", valid_cnt - v0); end
    n_cmp++; if (cube !== 3'd6) begin n_bad++; $display("FAIL load_cube: got %0d want 6", cube); end
    $display("test_loading: loading=%b", loading);
  endtask

  task automatic test_frame_coincide();
    logic [7:0] rx;
    cs_low();
    spi_byte(8'h01, 8, rx);
    spi_byte(8'h01, 7, rx);
    mosi = 1'b1;
    wait_cyc(6);
    sclk = 1'b1;
    wait_cyc(5);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("FAIL coincide_valid: got %b want 1", cmd_valid); end
    new_frame = 1'b1;
    wait_cyc(1);
    new_frame = 1'b0;
    sclk = 1'b0;
    n_cmp++; if (cube !== 3'd6) begin n_bad++; $display("FAIL coincide_old_commit: got %0d want 6", cube); end
    cs_high();
    frame();
    n_cmp++; if (cube !== 3'd1) begin n_bad++; $display("FAIL coincide_next_frame: got %0d want 1", cube); end
    $display("test_frame_coincide: cube=%0d", cube);
  endtask

  task automatic test_error();
    logic [7:0] st;
    logic [7:0] rx;
    int v0;
    v0 = valid_cnt;
    send_cmd(8'h7F, 8'h01, st);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_opcode_err: got %b want 1", err); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL bad_opcode_pulses: got %0d want 0", valid_cnt - v0); end
    cs_low();
    spi_byte(8'h01, 8, rx);
    spi_byte(8'h07, 3, rx);
    cs_high();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL short_frame_err: got %b want 1", err); end
    n_cmp++; if (cube !== 3'd1) begin n_bad++; $display("FAIL short_frame_cube: got %0d want 1", cube); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL short_frame_pulses: got %0d want 0", valid_cnt - v0); end
    send_cmd(8'h00, 8'h00, st);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL nop_clears_err: got %b want 0", err); end
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL nop_pulse: got %0d want 1", valid_cnt - v0); end
    cs_low();
    spi_byte(8'h01, 8, rx);
    cs_high();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL byte_boundary_err: got %b want 1", err); end
    send_cmd(8'h00, 8'h00, st);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL nop_clears_err2: got %b want 0", err); end
    $display("test_error: err=%b cube=%0d", err, cube);
  endtask

  task automatic test_status();
    logic [7:0] st;
    logic [7:0] rx;
    int v0;
    do_reset();
    send_cmd(8'h01, 8'h02, st);
    send_cmd(8'h02, 8'h00, st);
    frame();
    n_cmp++; if (cube !== 3'd2) begin n_bad++; $display("FAIL status_cube: got %0d want 2", cube); end
    v0 = valid_cnt;
    cs_low();
    spi_byte(8'h00, 8, st);
    n_cmp++; if (st !== 8'h42) begin n_bad++; $display("FAIL status_byte: got %h want 42", st); end
    spi_byte(8'h00, 4, rx);
    n_cmp++; if (rx !== 8'h00) begin n_bad++; $display("FAIL status_miso_byte1: got %h want 00", rx); end
    wait_cyc(4200);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    cs_high();
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL timeout_pulses: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL timeout_loading: got %b want 1", loading); end
    send_cmd(8'h00, 8'h00, st);
    n_cmp++; if (st !== 8'hC2) begin n_bad++; $display("FAIL status_with_err: got %h want c2", st); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL status_nop_clear: got %b want 0", err); end
    $display("test_status: status=%h", st);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic m;
    int v0;
    cs_low();
    spi_byte(8'h01, 8, rx);
    spi_byte(8'h07, 3, rx);
    #2 iRST_n = 1'b0;
    #1;
    n_cmp++; if (cube !== 3'd0) begin n_bad++; $display("FAIL async_cube: got %0d want 0", cube); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL async_loading: got %b want 0", loading); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b want 0", err); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL async_miso: got %b want 0", miso); end
    v0 = valid_cnt;
    spi_bit(1'b1, m);
    spi_bit(1'b1, m);
    iRST_n = 1'b1;
    spi_bit(1'b1, m);
    spi_bit(1'b1, m);
    spi_bit(1'b1, m);
    spi_byte(8'h02, 8, rx);
    spi_byte(8'h00, 8, rx);
    wait_cyc(10);
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL post_reset_ignored: got %0d pulses want 0", valid_cnt - v0); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL post_reset_loading: got %b want 0", loading); end
    cs_high();
    send_cmd(8'h01, 8'h04, rx);
    frame();
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL post_reset_cmd: got %0d pulses want 1", valid_cnt - v0); end
    n_cmp++; if (cube !== 3'd4) begin n_bad++; $display("FAIL post_reset_cube: got %0d want 4", cube); end
    $display("test_reset_mid: cube=%0d", cube);
  endtask

  initial begin
    test_reset();
    test_set_cube();
    test_overwrite();
    test_loading();
    test_frame_coincide();
    test_error();
    test_status();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
